// File: rtl/sodor_pkg.sv
// Shared constants for the Sodor single-cycle RV32I tile: encodings, CSR map,
// memory map and the ALU helper used by the core.
package sodor_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SR = 3'b101, F3_OR = 3'b110, F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LBU = 3'b100, F3_LHU = 3'b101;

  localparam logic [11:0] CSR_MSTATUS = 12'h300, CSR_MTVEC = 12'h305, CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC = 12'h341, CSR_MCAUSE = 12'h342;
  localparam logic [11:0] SYS_ECALL = 12'h000, SYS_EBREAK = 12'h001, SYS_MRET = 12'h302;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2, CAUSE_BREAK = 32'd3, CAUSE_ECALL = 32'd11;

  localparam int TEXT_WORDS  = 600;
  localparam int DATA_WORDS  = 192;
  localparam int STACK_WORDS = 128;
  localparam int TEXT_AW  = 10;
  localparam int DATA_AW  = 8;
  localparam int STACK_AW = 7;
  localparam logic [31:0] TEXT_BASE   = 32'h8000_0000, TEXT_BYTES  = 32'd2400;
  localparam logic [31:0] DATA_BASE   = 32'h8000_1000, DATA_BYTES  = 32'h300;
  localparam logic [31:0] STACK_BASE  = 32'h8002_1000, STACK_BYTES = 32'h200;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic [31:0] alu_calc(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      F3_ADD:  r = alt ? a - b : a + b;
      F3_SLL:  r = a << b[4:0];
      F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
      F3_SLTU: r = {31'b0, a < b};
      F3_XOR:  r = a ^ b;
      F3_SR:   r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      F3_OR:   r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sodor_core.sv
// Single-cycle RV32I datapath: decode, ALU, branch unit, register file and
// machine-mode CSRs; every instruction retires on the clock edge it is fetched for.
module sodor_core
  import sodor_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] io_imem_req_bits_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_wen,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] rf [32];
  logic [31:0] mstatus_reg, mtvec_reg, mepc_reg, mcause_reg, mscratch_reg;

  opcode_e     opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_b, alu_out, load_shifted, load_val;
  logic [31:0] csr_rdata, csr_src, csr_wdata, wb_data, trap_cause;
  logic [4:0]  byte_shift;
  logic        alu_alt, br_taken, rd_wen, csr_wen, trap;

  assign io_imem_req_bits_addr = pc_reg;

  assign opcode   = opcode_e'(imem_data[6:0]);
  assign rd       = imem_data[11:7];
  assign funct3   = imem_data[14:12];
  assign rs1      = imem_data[19:15];
  assign rs2      = imem_data[24:20];
  assign csr_addr = imem_data[31:20];
  assign imm_i = {{20{imem_data[31]}}, imem_data[31:20]};
  assign imm_s = {{20{imem_data[31]}}, imem_data[31:25], imem_data[11:7]};
  assign imm_b = {{20{imem_data[31]}}, imem_data[7], imem_data[30:25], imem_data[11:8], 1'b0};
  assign imm_u = {imem_data[31:12], 12'b0};
  assign imm_j = {{12{imem_data[31]}}, imem_data[19:12], imem_data[20], imem_data[30:21], 1'b0};

  // rf[0] is reset to zero and never written, so x0 reads as zero without a mux
  assign rs1_val = rf[rs1];
  assign rs2_val = rf[rs2];

  // For immediates, bit 30 only means "arithmetic" on shifts; ADDI with a negative imm must not subtract
  assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
  assign alu_alt = imem_data[30] && ((opcode == OP_REG) || (funct3 == F3_SR));
  assign alu_out = alu_calc(funct3, alu_alt, rs1_val, alu_b);

  always_comb begin
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val < rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  assign dmem_addr    = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign byte_shift   = {dmem_addr[1:0], 3'b000};
  assign load_shifted = dmem_rdata >> byte_shift;
  assign dmem_wdata   = rs2_val << byte_shift;

  always_comb begin
    case (funct3)
      F3_LB:   load_val = {{24{load_shifted[7]}}, load_shifted[7:0]};
      F3_LH:   load_val = {{16{load_shifted[15]}}, load_shifted[15:0]};
      F3_LBU:  load_val = {24'b0, load_shifted[7:0]};
      F3_LHU:  load_val = {16'b0, load_shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
    case (funct3[1:0])
      2'b00:   dmem_wmask = 4'b0001 << dmem_addr[1:0];
      2'b01:   dmem_wmask = 4'b0011 << dmem_addr[1:0];
      default: dmem_wmask = 4'b1111;
    endcase
  end

  always_comb begin
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = mstatus_reg;
      CSR_MTVEC:    csr_rdata = mtvec_reg;
      CSR_MEPC:     csr_rdata = mepc_reg;
      CSR_MCAUSE:   csr_rdata = mcause_reg;
      CSR_MSCRATCH: csr_rdata = mscratch_reg;
      default:      csr_rdata = 32'h0;
    endcase
    csr_src = funct3[2] ? {27'b0, rs1} : rs1_val;
    case (funct3[1:0])
      2'b01:   csr_wdata = csr_src;
      2'b10:   csr_wdata = csr_rdata | csr_src;
      2'b11:   csr_wdata = csr_rdata & ~csr_src;
      default: csr_wdata = csr_rdata;
    endcase
  end

  always_comb begin
    pc_next    = pc_reg + 32'd4;
    wb_data    = alu_out;
    rd_wen     = 1'b0;
    dmem_wen   = 1'b0;
    csr_wen    = 1'b0;
    trap       = 1'b0;
    trap_cause = 32'h0;
    case (opcode)
      OP_LUI:    begin rd_wen = 1'b1; wb_data = imm_u; end
      OP_AUIPC:  begin rd_wen = 1'b1; wb_data = pc_reg + imm_u; end
      OP_JAL:    begin rd_wen = 1'b1; wb_data = pc_reg + 32'd4; pc_next = pc_reg + imm_j; end
      OP_JALR:   begin rd_wen = 1'b1; wb_data = pc_reg + 32'd4; pc_next = (rs1_val + imm_i) & ~32'd1; end
      OP_BRANCH: if (br_taken) pc_next = pc_reg + imm_b;
      OP_LOAD:   begin rd_wen = 1'b1; wb_data = load_val; end
      OP_STORE:  dmem_wen = 1'b1;
      OP_IMM, OP_REG: rd_wen = 1'b1;
      OP_FENCE:  ;
      OP_SYSTEM: begin
        if (funct3 == 3'b000) begin
          case (csr_addr)
            SYS_ECALL:  begin trap = 1'b1; trap_cause = CAUSE_ECALL; end
            SYS_EBREAK: begin trap = 1'b1; trap_cause = CAUSE_BREAK; end
            SYS_MRET:   pc_next = mepc_reg;
            default:    ;
          endcase
        end else begin
          rd_wen  = 1'b1;
          wb_data = csr_rdata;
          csr_wen = 1'b1;
        end
      end
      default: begin trap = 1'b1; trap_cause = CAUSE_ILLEGAL; end
    endcase
    if (trap) begin
      pc_next  = mtvec_reg;
      rd_wen   = 1'b0;
      dmem_wen = 1'b0;
      csr_wen  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_reg       <= RESET_PC;
      mstatus_reg  <= '0;
      mtvec_reg    <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
      mscratch_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      if (trap) begin
        mepc_reg   <= pc_reg;
        mcause_reg <= trap_cause;
      end else if (csr_wen) begin
        case (csr_addr)
          CSR_MSTATUS:  mstatus_reg  <= csr_wdata;
          CSR_MTVEC:    mtvec_reg    <= {csr_wdata[31:2], 2'b00};
          CSR_MEPC:     mepc_reg     <= {csr_wdata[31:2], 2'b00};
          CSR_MCAUSE:   mcause_reg   <= csr_wdata;
          CSR_MSCRATCH: mscratch_reg <= csr_wdata;
          default:      ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rd_wen && (rd != 5'd0)) begin
      rf[rd] <= wb_data;
    end
  end

endmodule

// File: rtl/sodor_mem.sv
// Word-organised memory with two combinational read ports and a byte-masked
// synchronous write port. Contents are deliberately not reset.
module sodor_mem #(
  parameter int WORDS = 16,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic [AW-1:0] raddr_a,
  output logic [31:0]   rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [31:0]   rdata_b,
  input  logic          wen,
  input  logic [3:0]    wmask,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [WORDS];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (wen && wmask[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/sodor_internal_tile.sv
// Standalone Sodor tile: one core plus text, data and stack memories, with the
// address decode that steers fetches, loads and stores between them.
module sodor_internal_tile
  import sodor_pkg::*;
(
  input logic clock,
  input logic reset
);

  logic [31:0] pc, inst, dmem_addr, dmem_rdata, dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic        dmem_wen;
  logic [31:0] pc_off, text_off, data_off, stack_off;
  logic        fetch_in_text, in_text, in_data, in_stack;
  logic [31:0] fetch_word, text_rdata, data_rdata, stack_rdata;
  logic [31:0] unused_data_b, unused_stack_b;

  sodor_core core (
    .clock                 (clock),
    .reset                 (reset),
    .io_imem_req_bits_addr (pc),
    .imem_data             (inst),
    .dmem_addr             (dmem_addr),
    .dmem_rdata            (dmem_rdata),
    .dmem_wen              (dmem_wen),
    .dmem_wmask            (dmem_wmask),
    .dmem_wdata            (dmem_wdata)
  );

  // Offsets wrap below each base, so a single unsigned compare is the range check
  assign pc_off    = pc - TEXT_BASE;
  assign text_off  = dmem_addr - TEXT_BASE;
  assign data_off  = dmem_addr - DATA_BASE;
  assign stack_off = dmem_addr - STACK_BASE;

  assign fetch_in_text = pc_off < TEXT_BYTES;
  assign in_text       = text_off < TEXT_BYTES;
  assign in_data       = data_off < DATA_BYTES;
  assign in_stack      = stack_off < STACK_BYTES;

  assign inst = fetch_in_text ? fetch_word : NOP_INST;

  always_comb begin
    if (in_text)       dmem_rdata = text_rdata;
    else if (in_data)  dmem_rdata = data_rdata;
    else if (in_stack) dmem_rdata = stack_rdata;
    else               dmem_rdata = 32'h0;
  end

  // Text is read-only from the core: stores there are dropped
  sodor_mem #(.WORDS(TEXT_WORDS), .AW(TEXT_AW)) mem_text (
    .clock   (clock),
    .raddr_a (pc_off[TEXT_AW+1:2]),
    .rdata_a (fetch_word),
    .raddr_b (text_off[TEXT_AW+1:2]),
    .rdata_b (text_rdata),
    .wen     (1'b0),
    .wmask   (dmem_wmask),
    .waddr   (text_off[TEXT_AW+1:2]),
    .wdata   (dmem_wdata)
  );

  sodor_mem #(.WORDS(DATA_WORDS), .AW(DATA_AW)) mem_data (
    .clock   (clock),
    .raddr_a (data_off[DATA_AW+1:2]),
    .rdata_a (data_rdata),
    .raddr_b (data_off[DATA_AW+1:2]),
    .rdata_b (unused_data_b),
    .wen     (dmem_wen && in_data),
    .wmask   (dmem_wmask),
    .waddr   (data_off[DATA_AW+1:2]),
    .wdata   (dmem_wdata)
  );

  sodor_mem #(.WORDS(STACK_WORDS), .AW(STACK_AW)) mem_stack (
    .clock   (clock),
    .raddr_a (stack_off[STACK_AW+1:2]),
    .rdata_a (stack_rdata),
    .raddr_b (stack_off[STACK_AW+1:2]),
    .rdata_b (unused_stack_b),
    .wen     (dmem_wen && in_stack),
    .wmask   (dmem_wmask),
    .waddr   (stack_off[STACK_AW+1:2]),
    .wdata   (dmem_wdata)
  );

endmodule

// File: tb/tb_sodor_internal_tile.sv
// Directed bench for the Sodor tile: hand-assembled programs are poked into
// the text memory and architectural state is compared with hand-computed values.
module tb_sodor_internal_tile;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] image [600];

  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JALR = 7'b1100111;
  localparam logic [6:0] LOAD = 7'b0000011, OPIMM = 7'b0010011, SYS = 7'b1110011;

  sodor_internal_tile dut (
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm[19:0], rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic clear_image();
    for (int i = 0; i < 600; i++) image[i] = 32'h0000_0013;
  endtask

  // Hold reset for 10 ns while the image is loaded, release on a falling edge
  task automatic boot();
    reset = 1'b0;
    for (int i = 0; i < 600; i++) dut.mem_text.mem[i] <= image[i];
    #10;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    clear_image();
    boot();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      vectors++;
      if (dut.core.io_imem_req_bits_addr !== exp_pc[i]) begin
        miscompares++;
        $display("FAIL reset_pc[%0d]: got %h expected %h", i, dut.core.io_imem_req_bits_addr, exp_pc[i]);
      end
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (dut.core.io_imem_req_bits_addr !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL reset_midrun_pc: got %h expected 80000000", dut.core.io_imem_req_bits_addr);
    end
    $display("test_reset: %0d vectors so far", vectors);
  endtask

  task automatic test_alu();
    int          regs  [11];
    logic [31:0] exp_v [11];
    regs  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 10};
    exp_v = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd0, 32'd1, 32'd8, 32'hFFFF_FFFE,
              32'hF, 32'h1234_5000, 32'd0, 32'h8000_1028};
    clear_image();
    image[0]  = enc_i(5, 0, 3'b000, 1, OPIMM);
    image[1]  = enc_i(-3, 0, 3'b000, 2, OPIMM);
    image[2]  = enc_r(7'h00, 2, 1, 3'b000, 3);
    image[3]  = enc_r(7'h00, 1, 2, 3'b011, 4);
    image[4]  = enc_r(7'h00, 1, 2, 3'b010, 5);
    image[5]  = enc_r(7'h20, 2, 1, 3'b000, 6);
    image[6]  = enc_i(32'h401, 2, 3'b101, 7, OPIMM);
    image[7]  = enc_i(28, 2, 3'b101, 8, OPIMM);
    image[8]  = enc_u(32'h12345, 9, LUI);
    image[9]  = enc_i(7, 0, 3'b000, 0, OPIMM);
    image[10] = enc_u(32'h1, 10, AUIPC);
    boot();
    repeat (11) @(negedge clock);
    for (int i = 0; i < 11; i++) begin
      vectors++;
      if (dut.core.rf[regs[i]] !== exp_v[i]) begin
        miscompares++;
        $display("FAIL alu x%0d: got %h expected %h", regs[i], dut.core.rf[regs[i]], exp_v[i]);
      end
    end
    vectors++;
    if (dut.core.io_imem_req_bits_addr !== 32'h8000_002C) begin
      miscompares++;
      $display("FAIL alu_pc: got %h expected 8000002c", dut.core.io_imem_req_bits_addr);
    end
    $display("test_alu: %0d vectors so far", vectors);
  endtask

  task automatic test_branch();
    logic [31:0] exp_pc [12];
    exp_pc = '{32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_0010,
               32'h8000_0018, 32'h8000_001C, 32'h8000_0020, 32'h8000_0024,
               32'h8000_002C, 32'h8000_003C, 32'h8000_0034, 32'h8000_0000};
    clear_image();
    image[0]  = enc_i(-1, 0, 3'b000, 1, OPIMM);
    image[1]  = enc_i(1, 0, 3'b000, 2, OPIMM);
    image[4]  = enc_b(8, 2, 1, 3'b100);
    image[6]  = enc_b(8, 2, 1, 3'b110);
    image[7]  = enc_b(8, 1, 1, 3'b100);
    image[8]  = enc_b(8, 2, 1, 3'b101);
    image[9]  = enc_b(8, 2, 1, 3'b111);
    image[11] = enc_j(16, 5);
    image[13] = enc_b(-52, 2, 1, 3'b001);
    image[15] = enc_i(5, 5, 3'b000, 6, JALR);
    boot();
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      vectors++;
      if (dut.core.io_imem_req_bits_addr !== exp_pc[i]) begin
        miscompares++;
        $display("FAIL branch_pc[%0d]: got %h expected %h", i, dut.core.io_imem_req_bits_addr, exp_pc[i]);
      end
    end
    vectors++;
    if (dut.core.rf[5] !== 32'h8000_0030) begin
      miscompares++;
      $display("FAIL jal_link: got %h expected 80000030", dut.core.rf[5]);
    end
    vectors++;
    if (dut.core.rf[6] !== 32'h8000_0040) begin
      miscompares++;
      $display("FAIL jalr_link: got %h expected 80000040", dut.core.rf[6]);
    end
    $display("test_branch: %0d vectors so far", vectors);
  endtask

  task automatic test_memory();
    int          regs  [8];
    logic [31:0] exp_v [8];
    clear_image();
    image[0]  = enc_u(32'h80001, 1, LUI);
    image[1]  = enc_u(32'h12345, 2, LUI);
    image[2]  = enc_i(32'h678, 2, 3'b000, 2, OPIMM);
    image[3]  = enc_s(0, 2, 1, 3'b010);
    image[4]  = enc_i(0, 1, 3'b000, 3, LOAD);
    image[5]  = enc_i(2, 1, 3'b001, 4, LOAD);
    image[6]  = enc_i(32'h80, 0, 3'b000, 5, OPIMM);
    image[7]  = enc_s(1, 5, 1, 3'b000);
    image[8]  = enc_i(1, 1, 3'b100, 6, LOAD);
    image[9]  = enc_i(1, 1, 3'b000, 7, LOAD);
    image[10] = enc_i(0, 1, 3'b010, 8, LOAD);
    image[11] = enc_u(32'h80000, 9, LUI);
    image[12] = enc_s(0, 2, 9, 3'b010);
    image[13] = enc_i(0, 9, 3'b010, 10, LOAD);
    image[14] = enc_u(32'h80021, 11, LUI);
    image[15] = enc_s(0, 0, 11, 3'b010);
    image[16] = enc_s(2, 2, 11, 3'b001);
    image[17] = enc_i(0, 11, 3'b010, 12, LOAD);
    image[18] = enc_u(32'h90000, 13, LUI);
    image[19] = enc_i(1, 0, 3'b000, 14, OPIMM);
    image[20] = enc_i(0, 13, 3'b010, 14, LOAD);
    regs  = '{3, 4, 6, 7, 8, 10, 12, 14};
    exp_v = '{32'h78, 32'h1234, 32'h80, 32'hFFFF_FF80, 32'h1234_8078,
              image[0], 32'h5678_0000, 32'h0};
    boot();
    repeat (21) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dut.core.rf[regs[i]] !== exp_v[i]) begin
        miscompares++;
        $display("FAIL mem_load x%0d: got %h expected %h", regs[i], dut.core.rf[regs[i]], exp_v[i]);
      end
    end
    vectors++;
    if (dut.mem_text.mem[0] !== image[0]) begin
      miscompares++;
      $display("FAIL text_store_dropped: got %h expected %h", dut.mem_text.mem[0], image[0]);
    end
    vectors++;
    if (dut.mem_data.mem[0] !== 32'h1234_8078) begin
      miscompares++;
      $display("FAIL data_word: got %h expected 12348078", dut.mem_data.mem[0]);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (dut.mem_data.mem[0] !== 32'h1234_8078) begin
      miscompares++;
      $display("FAIL data_kept_over_reset: got %h expected 12348078", dut.mem_data.mem[0]);
    end
    vectors++;
    if (dut.core.rf[3] !== 32'h0) begin
      miscompares++;
      $display("FAIL rf_reset_x3: got %h expected 00000000", dut.core.rf[3]);
    end
    $display("test_memory: %0d vectors so far", vectors);
  endtask

  task automatic test_trap();
    clear_image();
    image[0]  = enc_u(32'h80000, 1, LUI);
    image[1]  = enc_i(32'h103, 1, 3'b000, 1, OPIMM);
    image[2]  = enc_i(32'h305, 1, 3'b001, 0, SYS);
    image[3]  = enc_i(32'h305, 0, 3'b010, 2, SYS);
    image[4]  = 32'h0000_0073;
    image[64] = enc_i(32'h341, 0, 3'b010, 5, SYS);
    image[65] = enc_i(5, 0, 3'b000, 6, OPIMM);
    image[66] = enc_i(32'hF14, 0, 3'b010, 6, SYS);
    image[67] = enc_i(32'h342, 0, 3'b010, 7, SYS);
    image[68] = 32'h3020_0073;
    boot();
    repeat (4) @(negedge clock);
    vectors++;
    if (dut.core.rf[2] !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL mtvec_read: got %h expected 80000100", dut.core.rf[2]);
    end
    vectors++;
    if (dut.core.io_imem_req_bits_addr !== 32'h8000_0010) begin
      miscompares++;
      $display("FAIL pre_ecall_pc: got %h expected 80000010", dut.core.io_imem_req_bits_addr);
    end
    @(negedge clock);
    vectors++;
    if (dut.core.io_imem_req_bits_addr !== 32'h8000_0100) begin
      miscompares++;
      $display("FAIL ecall_pc: got %h expected 80000100", dut.core.io_imem_req_bits_addr);
    end
    vectors++;
    if (dut.core.mepc_reg !== 32'h8000_0010) begin
      miscompares++;
      $display("FAIL ecall_mepc: got %h expected 80000010", dut.core.mepc_reg);
    end
    vectors++;
    if (dut.core.mcause_reg !== 32'd11) begin
      miscompares++;
      $display("FAIL ecall_mcause: got %h expected 0000000b", dut.core.mcause_reg);
    end
    repeat (4) @(negedge clock);
    vectors++;
    if (dut.core.rf[5] !== 32'h8000_0010) begin
      miscompares++;
      $display("FAIL csr_mepc_read: got %h expected 80000010", dut.core.rf[5]);
    end
    vectors++;
    if (dut.core.rf[6] !== 32'h0) begin
      miscompares++;
      $display("FAIL mhartid_read: got %h expected 00000000", dut.core.rf[6]);
    end
    vectors++;
    if (dut.core.rf[7] !== 32'd11) begin
      miscompares++;
      $display("FAIL csr_mcause_read: got %h expected 0000000b", dut.core.rf[7]);
    end
    @(negedge clock);
    vectors++;
    if (dut.core.io_imem_req_bits_addr !== 32'h8000_0010) begin
      miscompares++;
      $display("FAIL mret_pc: got %h expected 80000010", dut.core.io_imem_req_bits_addr);
    end
    $display("test_trap: %0d vectors so far", vectors);
  endtask

  task automatic test_illegal();
    clear_image();
    image[0]  = enc_u(32'h80000, 1, LUI);
    image[1]  = enc_i(32'h40, 1, 3'b000, 1, OPIMM);
    image[2]  = enc_i(32'h305, 1, 3'b001, 0, SYS);
    image[4]  = 32'h0000_0000;
    image[16] = 32'h0010_0073;
    boot();
    repeat (5) @(negedge clock);
    vectors++;
    if (dut.core.io_imem_req_bits_addr !== 32'h8000_0040) begin
      miscompares++;
      $display("FAIL illegal_pc: got %h expected 80000040", dut.core.io_imem_req_bits_addr);
    end
    vectors++;
    if (dut.core.mcause_reg !== 32'd2) begin
      miscompares++;
      $display("FAIL illegal_mcause: got %h expected 00000002", dut.core.mcause_reg);
    end
    vectors++;
    if (dut.core.mepc_reg !== 32'h8000_0010) begin
      miscompares++;
      $display("FAIL illegal_mepc: got %h expected 80000010", dut.core.mepc_reg);
    end
    @(negedge clock);
    vectors++;
    if (dut.core.mcause_reg !== 32'd3) begin
      miscompares++;
      $display("FAIL ebreak_mcause: got %h expected 00000003", dut.core.mcause_reg);
    end
    vectors++;
    if (dut.core.mepc_reg !== 32'h8000_0040) begin
      miscompares++;
      $display("FAIL ebreak_mepc: got %h expected 80000040", dut.core.mepc_reg);
    end
    $display("test_illegal: %0d vectors so far", vectors);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_memory();
    test_trap();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
